sprite_rom_reader: RTL and testbench
====================================

# sprite_rom_reader

Streaming read engine for the single-port sprite ROMs (16-bit pixels, 10-bit address, unregistered output, 1-cycle read latency) used by the FlappyBird renderer. On a start command it walks a contiguous address run in the ROM and presents the pixels on a valid/ready stream, with a colour-key transparency flag and a last-pixel marker. It sits between the sprite ROM and the pixel compositor, absorbs the ROM latency, and sustains one pixel per clock under continuous ready.

## Interface
Parameters:
- ADDR_WIDTH, 10, ROM address width
- DATA_WIDTH, 16, pixel width (RGB565)
- DEPTH, 990, valid ROM words; addresses run 0..DEPTH-1
- KEY_COLOR, 16'hF81F, transparent colour key

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command pulse; sampled only when busy=0
- base_addr  in  ADDR_WIDTH  first ROM word; must be < DEPTH
- length  in  ADDR_WIDTH+1  pixel count, 0..DEPTH
- abort  in  1  cancel current run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- rom_addr  out  ADDR_WIDTH  to ROM addra
- rom_data  in  DATA_WIDTH  from ROM doa; valid the cycle after rom_addr changes
- m_valid  out  1  pixel available
- m_ready  in  1  consumer accepts
- m_data  out  DATA_WIDTH  pixel
- m_transp  out  1  m_data == KEY_COLOR
- m_last  out  1  final pixel of the run

## Operation
- States: IDLE, RUN, DRAIN. Reset values: state IDLE, busy 0, done 0, rom_addr 0, m_valid 0, m_data 0, m_transp 0, m_last 0, all counters and FIFO pointers 0.
- IDLE: start=1 with length>0 -> latch length into issue and accept counters, load rom_addr=base_addr, go RUN, busy=1. start=1 with length=0 -> stay IDLE, done=1 next cycle, no pixels. start while busy is ignored.
- RUN: one address is issued per cycle while issue_cnt>0 and (FIFO occupancy + in-flight) < 2. Issuing means the ROM word at rom_addr is captured into the 2-entry output FIFO one cycle later, and rom_addr advances. rom_addr holds when not issuing. When issue_cnt reaches 0, go DRAIN.
- Address advance: rom_addr+1, wrapping to 0 after DEPTH-1 (not 2^ADDR_WIDTH-1).
- Output: m_data/m_transp come from the FIFO head; m_valid = FIFO non-empty. A pixel is consumed on m_valid&m_ready. m_last=1 only on the head entry whose accept count equals 1.
- DRAIN: when the last pixel is consumed, go IDLE, busy=0, done=1 for one cycle.
- abort=1 in RUN or DRAIN: next cycle FIFO flushed, in-flight read discarded, m_valid=0, counters cleared, state IDLE, busy=0, done=1. abort in IDLE has no effect. abort has priority over a same-cycle handshake; that pixel counts as not delivered.
- m_data must stay stable while m_valid=1 and m_ready=0.

## Timing
- Start accepted at edge E0: rom_addr=base_addr after E0; ROM data valid after E0; FIFO write at E1; m_valid=1 after E1 (first-pixel latency 2 cycles).
- m_ready held high: one pixel per cycle, with no bubbles. A run of N pixels completes its last handshake at edge E0+N+1. done is high during the cycle after that handshake, and busy falls at the same time.
- Backpressure: at most 2 pixels buffered. Issue stops within the same cycle that occupancy+in-flight reaches 2, so there is no FIFO overflow at any ready pattern.
- done and a new start are both legal in the same cycle as done: start is sampled because busy=0.
- rst_n assertion at any point forces reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- base=0, length=4, m_ready=1, ROM word[i]=i+1 -> m_data 1,2,3,4 on consecutive cycles starting 2 cycles after start; m_last on 4; done 1 cycle after.
- base=988, length=4, DEPTH=990 -> rom_addr sequence 988,989,0,1; data matches those words.
- length=6, m_ready toggling 1,0,0,1,0,1… -> all 6 pixels in order, none duplicated or lost, m_data stable while stalled.
- Word equal to 16'hF81F at address 5, base=3, length=4 -> m_transp=1 only on the third pixel.
- abort asserted after 2 accepted pixels of a 10-pixel run -> m_valid=0 next cycle, busy=0, done pulse. A new start with base=7, length=1 then yields exactly word[7] with m_last=1.
- length=0 start -> done after 1 cycle with m_valid never high. rst_n pulled low during RUN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/sprite_rom_reader.sv
// Streaming sprite ROM reader: walks a contiguous, DEPTH-wrapped address run and
// presents the pixels on a valid/ready stream with a colour-key flag and a last marker.
module sprite_rom_reader #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 990,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 16'hF81F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_transp,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

    state_t                  state_r;
    logic [ADDR_WIDTH:0]     issue_cnt_r;
    logic [ADDR_WIDTH:0]     accept_cnt_r;
    logic [1:0]              count_r;
    logic [DATA_WIDTH-1:0]   tail_data_r;
    logic                    tail_transp_r;
    logic                    tail_last_r;

    logic                    push_s;
    logic                    pop_s;
    logic                    push_last_s;
    logic                    push_transp_s;
    logic [ADDR_WIDTH-1:0]   next_addr_s;
    logic [DATA_WIDTH-1:0]   head_data_s;
    logic                    head_transp_s;
    logic                    head_last_s;
    logic [DATA_WIDTH-1:0]   tail_data_s;
    logic                    tail_transp_s;
    logic                    tail_last_s;
    logic [1:0]              count_s;

    // Issue/consume decisions and the DEPTH-wrapped next address.
    always_comb begin
        pop_s         = m_valid & m_ready;
        push_s        = (state_r == RUN) && (issue_cnt_r != CNT_ZERO) && (count_r < 2'd2);
        push_last_s   = (issue_cnt_r == CNT_ONE);
        push_transp_s = (rom_data == KEY_COLOR);
        if (rom_addr == LAST_ADDR) begin
            next_addr_s = ADDR_ZERO;
        end else begin
            next_addr_s = rom_addr + ADDR_ONE;
        end
    end

    // Two-entry shift FIFO: the head entry is the output register itself, so the
    // pixel presented on the stream only moves on a pop or a write into an empty FIFO.
    always_comb begin
        head_data_s   = m_data;
        head_transp_s = m_transp;
        head_last_s   = m_last;
        tail_data_s   = tail_data_r;
        tail_transp_s = tail_transp_r;
        tail_last_s   = tail_last_r;
        count_s       = count_r;
        if (pop_s) begin
            head_data_s   = tail_data_r;
            head_transp_s = tail_transp_r;
            head_last_s   = tail_last_r;
            count_s       = count_r - 2'd1;
        end else begin
            count_s       = count_r;
        end
        if (push_s) begin
            if (count_s == 2'd0) begin
                head_data_s   = rom_data;
                head_transp_s = push_transp_s;
                head_last_s   = push_last_s;
            end else begin
                tail_data_s   = rom_data;
                tail_transp_s = push_transp_s;
                tail_last_s   = push_last_s;
            end
            count_s = count_s + 2'd1;
        end else begin
            count_s = count_s;
        end
        if (count_s == 2'd0) begin
            head_last_s = 1'b0;
        end else begin
            head_last_s = head_last_s;
        end
    end

    // Run-control FSM with registered stream outputs and FIFO state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rom_addr      <= ADDR_ZERO;
            issue_cnt_r   <= CNT_ZERO;
            accept_cnt_r  <= CNT_ZERO;
            count_r       <= 2'd0;
            m_valid       <= 1'b0;
            m_data        <= DATA_ZERO;
            m_transp      <= 1'b0;
            m_last        <= 1'b0;
            tail_data_r   <= DATA_ZERO;
            tail_transp_r <= 1'b0;
            tail_last_r   <= 1'b0;
        end else if (abort && (state_r != IDLE)) begin
            // Abort wins over a same-cycle handshake and drops any read in flight.
            state_r      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b1;
            issue_cnt_r  <= CNT_ZERO;
            accept_cnt_r <= CNT_ZERO;
            count_r      <= 2'd0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            tail_last_r  <= 1'b0;
        end else begin
            done          <= 1'b0;
            m_data        <= head_data_s;
            m_transp      <= head_transp_s;
            m_last        <= head_last_s;
            tail_data_r   <= tail_data_s;
            tail_transp_r <= tail_transp_s;
            tail_last_r   <= tail_last_s;
            count_r       <= count_s;
            m_valid       <= (count_s != 2'd0);
            if (pop_s) begin
                accept_cnt_r <= accept_cnt_r - CNT_ONE;
            end
            if (push_s) begin
                rom_addr    <= next_addr_s;
                issue_cnt_r <= issue_cnt_r - CNT_ONE;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (length != CNT_ZERO) begin
                            issue_cnt_r  <= length;
                            accept_cnt_r <= length;
                            rom_addr     <= base_addr;
                            busy         <= 1'b1;
                            state_r      <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (push_s && push_last_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_s && (accept_cnt_r == CNT_ONE)) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_rom_reader.sv
// Directed + randomized bench for sprite_rom_reader: a ROM array drives rom_data and a
// queue of expected pixels, built from base/length/DEPTH, is checked at each handshake.
module tb_sprite_rom_reader;

    localparam int          AW    = 10;
    localparam int          DW    = 16;
    localparam int          DEPTH = 990;
    localparam logic [15:0] KEY   = 16'hF81F;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_transp;
    logic          m_last;

    logic [15:0] rom [0:DEPTH-1];
    int vectors = 0;
    int miscompares = 0;
    int ready_pat [6] = '{1, 0, 0, 1, 0, 1};

    sprite_rom_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .KEY_COLOR(KEY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_transp(m_transp),
        .m_last(m_last)
    );

    assign rom_data = (int'(rom_addr) < DEPTH) ? rom[rom_addr] : 16'h0000;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ready_pat[k % 6] != 0;
        return $urandom_range(0, 1) != 0;
    endfunction

    // mode 0: ready always high, 1: fixed toggle pattern, 2: random ready.
    // abort_after >= 0 raises abort once that many pixels have been accepted.
    task automatic do_run(input int base, input int len, input int mode, input int abort_after);
        logic [15:0] exp_q[$];
        int          accepted = 0;
        bit          fin = 0, aborted = 0, pv = 0, pr = 0, seen_valid = 0;
        logic [15:0] pd = 16'h0000;
        for (int i = 0; i < len; i++) exp_q.push_back(rom[(base + i) % DEPTH]);
        @(negedge clk);
        start = 1'b1; base_addr = AW'(base); length = (AW + 1)'(len);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("rom_addr_base", 32'(rom_addr), 32'(base));
        for (int k = 0; k < 400 && !fin; k++) begin
            if (k > 0) @(negedge clk);
            start = 1'b0;
            if (aborted) begin
                chk("abort_valid", 32'(m_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd1);
                abort = 1'b0;
                fin = 1;
            end else if (exp_q.size() == 0) begin
                chk("end_done", 32'(done), 32'd1);
                chk("end_busy", 32'(busy), 32'd0);
                chk("end_valid", 32'(m_valid), 32'd0);
                if (mode == 0) chk("done_latency", 32'(k), 32'(len + 1));
                fin = 1;
            end else begin
                chk("run_done_low", 32'(done), 32'd0);
                chk("run_busy", 32'(busy), 32'd1);
                if (mode == 0 && k < len) chk("rom_addr_seq", 32'(rom_addr), 32'((base + k) % DEPTH));
                if (pv && !pr) begin
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_data", 32'(m_data), 32'(pd));
                end
                if (m_valid && !seen_valid) begin
                    seen_valid = 1;
                    if (mode == 0) chk("first_latency", 32'(k), 32'd1);
                end
                if (mode == 2 && k == 3) begin
                    start = 1'b1;
                    base_addr = AW'($urandom_range(0, DEPTH - 1));
                    length = 11'd5;
                end
                m_ready = ready_for(mode, k);
                if (abort_after >= 0 && accepted == abort_after) begin
                    abort = 1'b1;
                    aborted = 1;
                end else if (m_valid && m_ready) begin
                    chk("pixel_data", 32'(m_data), 32'(exp_q[0]));
                    chk("pixel_transp", 32'(m_transp), 32'(exp_q[0] == KEY));
                    chk("pixel_last", 32'(m_last), 32'(exp_q.size() == 1));
                    void'(exp_q.pop_front());
                    accepted++;
                end
                pv = m_valid; pr = m_ready; pd = m_data;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int b, l, m;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        base_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'(i + 1);
        rom[5] = KEY;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        rst_n = 1'b1;

        do_run(0, 4, 0, -1);
        do_run(988, 4, 0, -1);
        do_run(20, 6, 1, -1);
        do_run(3, 4, 0, -1);
        do_run(30, 10, 0, 2);
        do_run(7, 1, 0, -1);

        // Zero-length command: done pulse, no pixels.
        @(negedge clk);
        start = 1'b1; base_addr = 10'd0; length = 11'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("len0_done_clr", 32'(done), 32'd0);
        chk("len0_valid2", 32'(m_valid), 32'd0);

        // Asynchronous reset in the middle of a stalled run.
        start = 1'b1; base_addr = 10'd10; length = 11'd8; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_valid", 32'(m_valid), 32'd0);
        chk("arst_data", 32'(m_data), 32'd0);
        chk("arst_transp", 32'(m_transp), 32'd0);
        chk("arst_last", 32'(m_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_run(100, 3, 0, -1);

        // Randomized runs over a randomized ROM image.
        for (int i = 0; i < DEPTH; i++)
            rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 16'($urandom);
        for (int r = 0; r < 16; r++) begin
            b = ($urandom_range(0, 1) != 0) ? 975 + int'($urandom_range(0, 14))
                                            : int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(1, 24));
            m = int'($urandom_range(0, 2));
            do_run(b, l, m, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
